// File: rtl/trackball_counter.sv
// trackball_counter: synchronised up/down trackball axis counters with a CPU snapshot read port.
// Define TRACKBALL_DEBOUNCE_EN to insert a stable-level filter after the synchronisers.
module trackball_counter #(
    parameter int SYNC_STAGES     = 2,
    parameter int CNT_WIDTH       = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 h_dir_in,
    input  logic                 h_clk_in,
    input  logic                 v_dir_in,
    input  logic                 v_clk_in,
    input  logic                 flip,
    input  logic                 latch,
    input  logic                 rd,
    input  logic                 sel,
    output logic [CNT_WIDTH-1:0] dout,
    output logic [CNT_WIDTH-1:0] h_count,
    output logic [CNT_WIDTH-1:0] v_count
);
`ifdef TRACKBALL_DEBOUNCE_EN
    localparam bit DEBOUNCE_ON = 1'b1;
`else
    localparam bit DEBOUNCE_ON = 1'b0;
`endif
    localparam int ARM_CYCLES = SYNC_STAGES + 1 + (DEBOUNCE_ON ? DEBOUNCE_CYCLES : 0);
    localparam int AW = $clog2(ARM_CYCLES + 1);

    // Bit order everywhere: {v_clk, v_dir, h_clk, h_dir}
    logic [3:0]           sync_q [SYNC_STAGES];
    logic [3:0]           sync_d [SYNC_STAGES];
    logic [3:0]           clean;
    logic [1:0]           prev_q, prev_d;
    logic [AW-1:0]        arm_q, arm_d;
    logic                 armed, h_rise, v_rise;
    logic [CNT_WIDTH-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [CNT_WIDTH-1:0] snap_h_q, snap_h_d, snap_v_q, snap_v_d;
    logic [CNT_WIDTH-1:0] dout_q, dout_d;

    always_comb begin
        sync_d[0] = {v_clk_in, v_dir_in, h_clk_in, h_dir_in};
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    end

`ifdef TRACKBALL_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [3:0]    filt_q, filt_d;
    logic [DW-1:0] db_cnt_q [4];
    logic [DW-1:0] db_cnt_d [4];

    // Output follows the input only once it has differed for DEBOUNCE_CYCLES samples in a row
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            filt_d[i]   = filt_q[i];
            db_cnt_d[i] = '0;
            if (sync_q[SYNC_STAGES-1][i] != filt_q[i]) begin
                if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) filt_d[i] = sync_q[SYNC_STAGES-1][i];
                else db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= '0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
        end else begin
            filt_q <= filt_d;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    assign clean = filt_q;
`else
    assign clean = sync_q[SYNC_STAGES-1];
`endif

    assign armed  = arm_q == AW'(ARM_CYCLES);
    assign h_rise = armed & clean[1] & ~prev_q[0];
    assign v_rise = armed & clean[3] & ~prev_q[1];

    always_comb begin
        arm_d    = armed ? arm_q : arm_q + 1'b1;
        prev_d   = {clean[3], clean[1]};
        h_cnt_d  = h_rise ? ((clean[0] ^ flip) ? h_cnt_q - 1'b1 : h_cnt_q + 1'b1) : h_cnt_q;
        v_cnt_d  = v_rise ? ((clean[2] ^ flip) ? v_cnt_q - 1'b1 : v_cnt_q + 1'b1) : v_cnt_q;
        snap_h_d = latch ? h_cnt_q : snap_h_q;
        snap_v_d = latch ? v_cnt_q : snap_v_q;
        dout_d   = rd ? (sel ? snap_v_q : snap_h_q) : dout_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q   <= '0;
            arm_q    <= '0;
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            snap_h_q <= '0;
            snap_v_q <= '0;
            dout_q   <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
            prev_q   <= prev_d;
            arm_q    <= arm_d;
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            snap_h_q <= snap_h_d;
            snap_v_q <= snap_v_d;
            dout_q   <= dout_d;
        end
    end

    assign dout    = dout_q;
    assign h_count = h_cnt_q;
    assign v_count = v_cnt_q;
endmodule

// File: tb/tb_trackball_counter.sv
// tb_trackball_counter: scoreboard bench for trackball_counter; a reference model pushes expected
// counter/read values as stimulus is driven and they are popped and compared once the DUT settles.
module tb_trackball_counter;
`ifdef TRACKBALL_DEBOUNCE_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 3;
`endif
    logic       clk = 0, reset_n = 0;
    logic       h_dir_in = 0, h_clk_in = 0, v_dir_in = 0, v_clk_in = 0;
    logic       flip = 0, latch = 0, rd = 0, sel = 0;
    logic [7:0] dout, h_count, v_count;
    int         checks = 0, errors = 0;
    int         exp_h = 0, exp_v = 0, snap_h = 0, snap_v = 0;

    typedef struct {
        string      tag;
        int         sig;
        logic [7:0] exp;
    } item_t;
    item_t sb_q [$];

    always #5 clk = ~clk;

    trackball_counter dut (
        .clk(clk), .reset_n(reset_n),
        .h_dir_in(h_dir_in), .h_clk_in(h_clk_in), .v_dir_in(v_dir_in), .v_clk_in(v_clk_in),
        .flip(flip), .latch(latch), .rd(rd), .sel(sel),
        .dout(dout), .h_count(h_count), .v_count(v_count)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int sig, input int exp);
        item_t it;
        it.tag = tag;
        it.sig = sig;
        it.exp = 8'(exp);
        sb_q.push_back(it);
    endtask

    task automatic drain();
        item_t it;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            check(it.tag, it.sig == 0 ? h_count : it.sig == 1 ? v_count : dout, it.exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int step(input int cnt, input logic dir);
        return (cnt + ((dir ^ flip) ? 255 : 1)) & 255;
    endfunction

    task automatic pulse(input bit h_en, input bit v_en, input string tag);
        if (h_en) begin h_clk_in = 1; exp_h = step(exp_h, h_dir_in); end
        if (v_en) begin v_clk_in = 1; exp_v = step(exp_v, v_dir_in); end
        cycles(8);
        h_clk_in = 0;
        v_clk_in = 0;
        cycles(8);
        push({tag, "_h"}, 0, exp_h);
        push({tag, "_v"}, 1, exp_v);
        drain();
    endtask

    // Horizontal pulse of len cycles, checking the count lands exactly LAT edges after the rise
    task automatic lat_pulse(input int len, input string tag);
        int old_h = exp_h;
        h_clk_in = 1;
        exp_h = step(exp_h, h_dir_in);
        cycles(LAT - 1);
        check({tag, "_before"}, h_count, 8'(old_h));
        cycles(1);
        check({tag, "_at"}, h_count, 8'(exp_h));
        cycles(len - LAT);
        h_clk_in = 0;
        cycles(10);
    endtask

    task automatic read(input logic s, input string tag);
        rd = 1;
        sel = s;
        cycles(1);
        rd = 0;
        push(tag, 2, s ? snap_v : snap_h);
        drain();
    endtask

    task automatic do_reset();
        reset_n = 0;
        #1;
        push("rst_async_h", 0, 0);
        push("rst_async_v", 1, 0);
        push("rst_async_dout", 2, 0);
        drain();
        exp_h = 0; exp_v = 0; snap_h = 0; snap_v = 0;
        cycles(3);
        reset_n = 1;
        cycles(12);
    endtask

    initial begin
        h_dir_in = 1; h_clk_in = 1; v_dir_in = 1; v_clk_in = 1;
        cycles(2);
        reset_n = 1;
        cycles(10);
        push("idle_high_h", 0, 0);
        push("idle_high_v", 1, 0);
        drain();
        do_reset();
        push("rst_high_h", 0, 0);
        push("rst_high_v", 1, 0);
        push("rst_high_dout", 2, 0);
        drain();
        h_dir_in = 0; h_clk_in = 0; v_dir_in = 0; v_clk_in = 0;
        cycles(6);
        push("fall_ignored_h", 0, 0);
        push("fall_ignored_v", 1, 0);
        drain();

        lat_pulse(8, "first_inc");
        repeat (4) pulse(1, 0, "h_up");
        push("h_five", 0, 5);
        push("v_idle", 1, 0);
        drain();

        do_reset();
        v_dir_in = 1;
        repeat (3) pulse(0, 1, "v_down");
        push("v_wrap_fd", 1, 8'hfd);
        drain();
        v_dir_in = 0;
        repeat (3) pulse(0, 1, "v_up");
        push("v_back_00", 1, 0);
        drain();

        repeat (5) pulse(1, 0, "h_up2");
        latch = 1;
        cycles(1);
        latch = 0;
        snap_h = exp_h; snap_v = exp_v;
        repeat (2) pulse(1, 0, "h_after_latch");
        read(0, "rd_snap_h");
        push("live_h_seven", 0, 7);
        drain();
        cycles(3);
        push("dout_hold", 2, snap_h);
        drain();
        read(1, "rd_snap_v");

        h_clk_in = 1;
        cycles(LAT - 1);
        latch = 1;
        cycles(1);
        latch = 0;
        snap_h = exp_h; snap_v = exp_v;
        exp_h = step(exp_h, h_dir_in);
        cycles(8 - LAT);
        h_clk_in = 0;
        cycles(8);
        push("latch_coinc_live", 0, exp_h);
        drain();
        read(0, "latch_coinc_snap");

        latch = 1; rd = 1; sel = 0;
        cycles(1);
        latch = 0; rd = 0;
        push("rd_latch_same", 2, snap_h);
        drain();
        snap_h = exp_h; snap_v = exp_v;
        read(0, "rd_after_latch");

        flip = 1;
        pulse(1, 0, "flip_h");
        v_dir_in = 1;
        pulse(0, 1, "flip_v");
        repeat (3) begin flip = ~flip; cycles(4); end
        push("flip_only_h", 0, exp_h);
        push("flip_only_v", 1, exp_v);
        drain();
        flip = 0; h_dir_in = 0; v_dir_in = 0;
        cycles(4);
        pulse(1, 1, "both_axes");

        h_clk_in = 1;
        cycles(2);
        do_reset();
        h_clk_in = 0;
        cycles(10);
        push("midop_rst_h", 0, 0);
        push("midop_rst_v", 1, 0);
        drain();

`ifdef TRACKBALL_DEBOUNCE_EN
        h_clk_in = 1;
        cycles(2);
        h_clk_in = 0;
        cycles(12);
        push("glitch_rejected", 0, exp_h);
        drain();
        lat_pulse(10, "db_pulse");
        push("db_pulse_total", 0, exp_h);
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/trackball_counter.md
Name: trackball_counter

Overview:
- Downstream consumer of the trackball emulator's (or SNAC's) h/v dir+clk outputs, standing in for the arcade board's up/down trackball counters.
- Synchronises the four asynchronous lines and counts rising edges of each axis clock, up or down according to the dir level.
- Provides a CPU-side snapshot latch and a registered 8-bit read port for the game CPU bus decoder.

Parameters:
- SYNC_STAGES, 2, flip-flops per input synchroniser; minimum 2.
- CNT_WIDTH, 8, width of each axis counter and of the read bus.
- DEBOUNCE_CYCLES, 4, stable-cycle count for the filter; only used when TRACKBALL_DEBOUNCE_EN is defined.

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- h_dir_in  in  1  horizontal direction, asynchronous.
- h_clk_in  in  1  horizontal count clock, asynchronous.
- v_dir_in  in  1  vertical direction, asynchronous.
- v_clk_in  in  1  vertical count clock, asynchronous.
- flip  in  1  cocktail flip; 1 inverts count direction on both axes.
- latch  in  1  single-cycle pulse; snapshots both counters.
- rd  in  1  single-cycle read strobe.
- sel  in  1  read select: 0 = horizontal snapshot, 1 = vertical snapshot.
- dout  out  CNT_WIDTH  registered read data.
- h_count  out  CNT_WIDTH  live horizontal counter.
- v_count  out  CNT_WIDTH  live vertical counter.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All synchroniser, edge-history, counter, snapshot and dout registers clear to 0.
  - The arm counter clears, so dout = h_count = v_count = 0 on assertion.
- Synchronisation:
  - Each input passes through its own SYNC_STAGES flop chain.
  - dir and clk of an axis use equal-depth chains, so they stay cycle-aligned.
- Edge detect:
  - A prev register holds the last synced clk value.
  - rise = synced_clk & ~prev. Falling edges are ignored, giving one count per full clk period.
- Arming:
  - After reset release, a small counter runs SYNC_STAGES+1 cycles before edge detection is enabled.
  - Until armed, prev tracks the synced clk but no count occurs. An input already high at release therefore produces no spurious count.
- Count rule per axis, on a rise cycle:
  - eff_dir = synced_dir XOR flip.
  - eff_dir = 0: counter += 1. eff_dir = 1: counter -= 1.
  - Modulo 2^CNT_WIDTH, wrapping silently: 0xFF+1 = 0x00 and 0x00-1 = 0xFF.
- Latency: an input transition set up before edge 1 is visible on h_count/v_count after edge SYNC_STAGES+1 (edge 3 at the default).
- Axes are fully independent; simultaneous edges on both update both counters in the same cycle.
- Latch:
  - On the cycle latch = 1, snap_h/snap_v load the current counter register values.
  - A count occurring in the same cycle is excluded from the snapshot and included in the live counter.
- Read:
  - rd = 1 at edge N: dout = sel ? snap_v : snap_h, valid after edge N.
  - dout holds its value while rd = 0.
  - rd and latch in the same cycle: dout returns the old snapshot.
- flip changes take effect on the next rise; counter contents are never modified by flip.
- Reset mid-operation: counts in flight are discarded and the arm sequence restarts.

Optional Feature:
- Macro: TRACKBALL_DEBOUNCE_EN.
- Defined:
  - Each synced clk and dir passes through a filter whose output changes only after the input has held a new value for DEBOUNCE_CYCLES consecutive cycles.
  - Pulses shorter than that are rejected.
  - Latency increases by DEBOUNCE_CYCLES.
  - Filter outputs reset to 0, and the arm period extends by DEBOUNCE_CYCLES.
- Undefined: no filter; synced signals feed edge detection directly.

Test Plan:
- Reset: drive inputs high, pulse reset_n low for 3 cycles, release → h_count = v_count = dout = 0, and no count occurs within 10 cycles.
- h_dir_in = 0, flip = 0, five h_clk_in pulses (8 cycles high / 8 low) → h_count = 0x05, v_count = 0x00; first increment appears 3 cycles after the first rise.
- From reset, v_dir_in = 1, three v_clk_in pulses → v_count = 0xFD (wrap); then v_dir_in = 0, three pulses → 0x00.
- h_count = 0x05; latch pulse; two more up-pulses; rd with sel = 0 → dout = 0x05 one cycle after rd while h_count = 0x07. A latch coincident with a count cycle captures the pre-count value.
- flip = 1, h_dir_in = 0, one h_clk_in pulse from 0x07 → h_count = 0x06. Toggling flip alone leaves the count unchanged.
- TRACKBALL_DEBOUNCE_EN defined, DEBOUNCE_CYCLES = 4:
  - 2-cycle h_clk_in glitch → no change.
  - 10-cycle pulse → exactly +1, appearing 4 cycles later than in the unfiltered build.
